// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Instruction buffer between fetch and decode. Fetched instructions and
//   their PC+4 are queued in order. The head entry is presented to decode.
//   Fetch is back-pressured through o_stall. A taken branch or jump (i_flush)
//   discards every buffered wrong-path entry.
//
// Handshake: an entry is written when i_instr_valid=1, there is room, and
//   no flush is in progress. The head entry leaves the queue when o_valid=1,
//   i_decode_ready=1, and no flush is in progress. A push made in cycle N
//   appears at the head in cycle N+1. There is no same-cycle bypass.
//
// Ports:
//   i_aclk          clock
//   i_areset        synchronous active-high reset
//   i_instruction   instruction from fetch
//   i_pcplus4       PC+4 paired with i_instruction
//   i_instr_valid   push request
//   o_stall         back-pressure to fetch (a function of registered count only)
//   i_flush         discard all entries
//   i_decode_ready  decode consumes the head this cycle
//   o_instruction   head instruction, NOP_INSTR when empty
//   o_pcplus4       head PC+4, 0 when empty
//   o_valid         head entry valid
//   o_count         current occupancy
//   o_overflow      sticky: push attempted while full, cleared only by reset
module fetch_decode_queue #(
    parameter int          ADDR_SIZE    = 32,
    parameter int          INST_SIZE    = 32,
    parameter int          DEPTH        = 4,
    parameter int          STALL_THRESH = DEPTH - 2,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                         i_aclk,
    input  logic                         i_areset,
    input  logic [INST_SIZE-1:0]         i_instruction,
    input  logic [ADDR_SIZE-1:0]         i_pcplus4,
    input  logic                         i_instr_valid,
    output logic                         o_stall,
    input  logic                         i_flush,
    input  logic                         i_decode_ready,
    output logic [INST_SIZE-1:0]         o_instruction,
    output logic [ADDR_SIZE-1:0]         o_pcplus4,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INST_SIZE-1:0] mem_instr [DEPTH];
    logic [ADDR_SIZE-1:0] mem_pc    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign pop  = ~empty & i_decode_ready & ~i_flush;
    // When the queue is full, a pop in the same cycle frees the slot that
    // the push needs, so the push is still accepted.
    assign push = i_instr_valid & (~full | pop) & ~i_flush;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (i_flush) begin
            // The flag is sticky and survives a flush.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_instr_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // The storage array is not reset. Its contents are not visible while
    // the count is zero.
    always_ff @(posedge i_aclk) begin
        if (push && !i_areset) begin
            mem_instr[wr_ptr] <= i_instruction;
            mem_pc[wr_ptr]    <= i_pcplus4;
        end
    end

    assign o_valid       = ~empty;
    assign o_instruction = empty ? INST_SIZE'(NOP_INSTR) : mem_instr[rd_ptr];
    assign o_pcplus4     = empty ? '0 : mem_pc[rd_ptr];
    assign o_stall       = (count >= CNT_W'(STALL_THRESH));
    assign o_count       = count;
    assign o_overflow    = overflow;

endmodule
